morse_tx_param: RTL and testbench
=================================

Name: morse_tx_param

Overview:
- Parametrised Morse-code letter transmitter that drives one LED/output bit with ITU-style timing:
  - dot = 1 unit, dash = 3 units
  - 1-unit gap between elements, configurable inter-letter gap.
- Pattern width, unit length and gap lengths are generic, replacing fixed 4-symbol, fixed-timing letter blinkers.
- Sits between a letter-select/encoder front end (switches or ROM) and a board LED or buzzer.
- start/busy/done handshake lets a sequencer chain letters back-to-back.

Parameters:
- MAX_LEN, 4, maximum symbols per letter; pattern width.
- CLKS_PER_UNIT, 25000000, clock cycles per Morse time unit (0.5 s at 50 MHz); must be >= 1.
- DASH_UNITS, 3, mark length of a dash in units.
- ELEM_GAP_UNITS, 1, off time between elements of one letter.
- LETTER_GAP_UNITS, 3, off time after the last element before done.
- LW, $clog2(MAX_LEN+1), width of length port (derived, not overridden).

Ports:
- CLOCK_50  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send; sampled only when busy=0.
- abort  input  1  synchronous cancel of the letter in progress.
- pattern  input  MAX_LEN  symbols, MSB sent first; 1 = dash, 0 = dot.
- length  input  LW  number of symbols to send, 0..MAX_LEN.
- led  output  1  Morse output; 1 during marks.
- busy  output  1  high from the cycle after accepted start until return to IDLE.
- done  output  1  one-cycle pulse on normal completion.

Behaviour:
- Reset values: led=0, busy=0, done=0, state=IDLE, all counters 0. Reset mid-letter returns to IDLE at the next edge with no done.
- All outputs are registered.
- States are IDLE, MARK, EGAP, LGAP.
- IDLE:
  - On start=1, latch pattern and length into a shift register and symbol counter.
  - A length > MAX_LEN is clamped to MAX_LEN.
  - If latched length=0, go directly to IDLE with done=1 on the next cycle, led never asserts.
  - Otherwise go to MARK.
- MARK:
  - led=1 for exactly CLKS_PER_UNIT cycles (dot) or DASH_UNITS*CLKS_PER_UNIT cycles (dash), selected by the shift-register MSB.
  - On exit, shift left by 1 and decrement the symbol count.
  - If count is now 0, go to LGAP; else go to EGAP.
- EGAP: led=0 for ELEM_GAP_UNITS*CLKS_PER_UNIT cycles, then go to MARK.
- LGAP: led=0 for LETTER_GAP_UNITS*CLKS_PER_UNIT cycles, then go to IDLE.
- Completion: the first IDLE cycle after LGAP has done=1 and busy=0.
  - start in that same cycle is accepted, so letters chain with no extra gap.
- Timing counter:
  - A unit counter 0..CLKS_PER_UNIT-1 plus a unit-count register time each state.
  - Both clear on every state entry, so durations are exact cycle counts with no drift.
- start while busy=1 is ignored. pattern and length are don't-care after acceptance.
- abort=1 in any non-IDLE state goes to IDLE next cycle with led=0, busy=0 and done=0.
- abort in IDLE has no effect.
- Priority: reset > abort > start. abort and start in the same IDLE cycle: start is accepted.

Optional Feature:
- Macro MORSE_REPEAT_EN.
- When defined:
  - Adds input port repeat (1 bit).
  - At the end of LGAP with repeat=1, the latched original pattern and length reload and the FSM enters MARK directly.
  - done pulses for one cycle at that reload, and busy stays 1.
  - abort still terminates.
- When undefined: no repeat port; every letter is single-shot as above.

Test Plan:
- Test parameters for all scenarios: CLKS_PER_UNIT=4, defaults otherwise.
- Letter K: start with pattern=4'b1010, length=3.
  - led high 12 cycles, low 4, high 4, low 4, high 12, then low.
  - busy high 48 cycles, then done=1 for 1 cycle.
- Letter E (single dot): pattern=4'b0000, length=1.
  - led high 4 cycles, low 12 cycles, then done.
  - Total busy is 16 cycles.
- length=0 start: led stays 0, done pulses on the cycle after start; length=7 behaves as length=4.
- Abort and reset mid-letter:
  - Letter J (4'b0111, length=4), abort asserted during the 2nd mark: led=0 and busy=0 next cycle, no done pulse.
  - Repeat with reset instead of abort: same result.
- Chaining: start held high continuously with K then N.
  - The second letter begins the cycle done pulses.
  - The gap between letters is exactly 12 cycles of led=0.
  - start pulses while busy are ignored.
- MORSE_REPEAT_EN with repeat=1 and letter M (4'b1100, length=2):
  - led pattern 12 high / 4 low / 12 high / 12 low repeats.
  - done pulses every 40 cycles, busy stays high.
  - Dropping repeat ends after the current pass.

Source files
------------

// File: rtl/morse_tx_param.sv
// morse_tx_param
// ---------------------------------------------------------------------------
// Sends one Morse letter on a single output bit. A dot is one time unit of
// mark and a dash is DASH_UNITS units. Elements are separated by
// ELEM_GAP_UNITS units of space, and the letter ends with LETTER_GAP_UNITS
// units of space.
//
// Optional feature: define MORSE_REPEAT_EN to add the repeat_en input. The
// port cannot be called "repeat" because that word is reserved in
// SystemVerilog. While repeat_en is high at the end of the letter gap, the
// letter that was latched at acceptance is reloaded and sent again. done
// pulses at each reload and busy stays high.
//
// Parameters:
//   MAX_LEN          symbols per letter (pattern width)
//   CLKS_PER_UNIT    clock cycles per Morse unit (>= 1)
//   DASH_UNITS       dash mark length in units
//   ELEM_GAP_UNITS   space between elements in units (>= 1)
//   LETTER_GAP_UNITS space after the last element in units (>= 1)
//   LW               width of length (derived)
//
// Ports:
//   CLOCK_50   in   system clock, rising edge
//   reset      in   synchronous active-high reset
//   start      in   send request
//   abort      in   cancel the letter in progress
//   repeat_en  in   (MORSE_REPEAT_EN only) resend the letter at its end
//   pattern    in   [MAX_LEN] symbols, MSB first, 1 = dash, 0 = dot
//   length     in   [LW] symbol count, values above MAX_LEN are clamped
//   led        out  1 during marks
//   busy       out  a letter is being sent
//   done       out  one-cycle completion pulse
//   state_dbg  out  current FSM state (IDLE=0, MARK=1, EGAP=2, LGAP=3)
//
// Handshake: start is taken in any cycle with busy=0. It is also taken in
// the last cycle of the letter gap, so held or back-to-back requests chain
// letters with no extra idle cycle. In that chained case the new letter's
// first mark cycle carries the done pulse of the previous letter. When
// start is taken, pattern and length are latched and may then change
// freely. busy rises in the cycle after acceptance. done is a one-cycle
// pulse. abort and reset end a letter silently, with no done pulse.
// Priority is reset > abort > start.
// ---------------------------------------------------------------------------
module morse_tx_param #(
   parameter  int MAX_LEN          = 4,
   parameter  int CLKS_PER_UNIT    = 25000000,
   parameter  int DASH_UNITS       = 3,
   parameter  int ELEM_GAP_UNITS   = 1,
   parameter  int LETTER_GAP_UNITS = 3,
   localparam int LW               = $clog2(MAX_LEN + 1)
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   input  logic               abort,
`ifdef MORSE_REPEAT_EN
   input  logic               repeat_en,
`endif
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LW-1:0]      length,
   output logic               led,
   output logic               busy,
   output logic               done,
   output logic [1:0]         state_dbg
);

   localparam int MAX_A     = (DASH_UNITS > ELEM_GAP_UNITS) ? DASH_UNITS : ELEM_GAP_UNITS;
   localparam int MAX_UNITS = (MAX_A > LETTER_GAP_UNITS) ? MAX_A : LETTER_GAP_UNITS;
   localparam int UCW       = (CLKS_PER_UNIT > 1) ? $clog2(CLKS_PER_UNIT) : 1;
   localparam int UNW       = (MAX_UNITS > 1) ? $clog2(MAX_UNITS) : 1;

   localparam logic [UCW-1:0] UNIT_LAST = UCW'(CLKS_PER_UNIT - 1);
   localparam logic [UNW-1:0] DOT_LAST  = '0;
   localparam logic [UNW-1:0] DASH_LAST = UNW'(DASH_UNITS - 1);
   localparam logic [UNW-1:0] EGAP_LAST = UNW'(ELEM_GAP_UNITS - 1);
   localparam logic [UNW-1:0] LGAP_LAST = UNW'(LETTER_GAP_UNITS - 1);
   localparam logic [LW-1:0]  LEN_MAX   = LW'(MAX_LEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MARK = 2'd1,
      EGAP = 2'd2,
      LGAP = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] shift_q, shift_d;
   logic [LW-1:0]      cnt_q, cnt_d;
   logic [UCW-1:0]     unit_cnt_q;
   logic [UNW-1:0]     unit_num_q;
   logic [UNW-1:0]     last_unit;
   logic [LW-1:0]      len_eff;
   logic               phase_end;
   logic               restart;
   logic               accept;
   logic               kill;
   logic               done_d;

`ifdef MORSE_REPEAT_EN
   logic [MAX_LEN-1:0] orig_pat_q;
   logic [LW-1:0]      orig_len_q;
`endif

   assign len_eff   = (length > LEN_MAX) ? LEN_MAX : length;
   assign kill      = abort && (state_q != IDLE);
   assign state_dbg = state_q;

   // Index of the last unit in the current state. In MARK it depends on
   // whether the symbol now at the head of the shift register is a dot or a
   // dash.
   always_comb begin
      last_unit = '0;
      unique case (state_q)
         MARK:    last_unit = shift_q[MAX_LEN-1] ? DASH_LAST : DOT_LAST;
         EGAP:    last_unit = EGAP_LAST;
         LGAP:    last_unit = LGAP_LAST;
         default: last_unit = '0;
      endcase
   end

   assign phase_end = (unit_cnt_q == UNIT_LAST) && (unit_num_q == last_unit);

   // Next-state logic. restart clears both timing counters, so every state
   // starts counting its exact duration from zero.
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;
      accept  = 1'b0;
      restart = 1'b0;

      unique case (state_q)
         IDLE: begin
            restart = 1'b1;
            if (start) accept = 1'b1;
         end
         MARK: begin
            if (phase_end) begin
               restart = 1'b1;
               shift_d = shift_q << 1;
               cnt_d   = cnt_q - LW'(1);
               state_d = (cnt_q == LW'(1)) ? LGAP : EGAP;
            end
         end
         EGAP: begin
            if (phase_end) begin
               restart = 1'b1;
               state_d = MARK;
            end
         end
         LGAP: begin
            if (phase_end) begin
               restart = 1'b1;
               done_d  = 1'b1;
               state_d = IDLE;
`ifdef MORSE_REPEAT_EN
               if (repeat_en) begin
                  shift_d = orig_pat_q;
                  cnt_d   = orig_len_q;
                  state_d = MARK;
               end else if (start) begin
                  accept = 1'b1;
               end
`else
               if (start) accept = 1'b1;
`endif
            end
         end
         default: state_d = IDLE;
      endcase

      // A zero-length letter completes at once and never enters MARK.
      if (accept) begin
         shift_d = pattern;
         cnt_d   = len_eff;
         if (len_eff == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end else begin
            state_d = MARK;
         end
      end

      if (kill) begin
         state_d = IDLE;
         shift_d = '0;
         cnt_d   = '0;
         done_d  = 1'b0;
         restart = 1'b1;
      end
   end

   // The outputs are registered from the next state, so led and busy line
   // up exactly with the state they describe.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q    <= IDLE;
         shift_q    <= '0;
         cnt_q      <= '0;
         unit_cnt_q <= '0;
         unit_num_q <= '0;
         led        <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
         if (restart) begin
            unit_cnt_q <= '0;
            unit_num_q <= '0;
         end else if (unit_cnt_q == UNIT_LAST) begin
            unit_cnt_q <= '0;
            unit_num_q <= unit_num_q + UNW'(1);
         end else begin
            unit_cnt_q <= unit_cnt_q + UCW'(1);
         end
         led  <= (state_d == MARK);
         busy <= (state_d != IDLE);
         done <= done_d;
      end
   end

`ifdef MORSE_REPEAT_EN
   // Copy of the accepted letter, kept for reloads while repeat_en is high.
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         orig_pat_q <= '0;
         orig_len_q <= '0;
      end else if (accept && !kill) begin
         orig_pat_q <= pattern;
         orig_len_q <= len_eff;
      end
   end
`endif

endmodule

// File: tb/tb_morse_tx_param.sv
module tb_morse_tx_param;

  localparam int C = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset, start, abort, repeat_en;
  logic [3:0] pattern;
  logic [2:0] length;
  logic       led, busy, done;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;
  int rep_drop_at = -1;

  // expected {led, busy, done} for each cycle after the accepting edge
  logic [2:0] exp_q[$];

  // clock / reset block
  always #5 CLOCK_50 = ~CLOCK_50;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach its end, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  morse_tx_param #(.CLKS_PER_UNIT(C)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
`ifdef MORSE_REPEAT_EN
    .repeat_en (repeat_en),
`endif
    .pattern   (pattern),
    .length    (length),
    .led       (led),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expands a letter into its per-cycle output sequence
  // from the Morse timing rules (dot 1 unit, dash 3, element gap 1,
  // letter gap 3, each unit C cycles). chained_in marks the first cycle as
  // also carrying the previous letter's done pulse. chained_out omits this
  // letter's idle done cycle because the next letter starts there.
  task automatic push_letter(input logic [3:0] pat, input int len,
                             input bit chained_in, input bit chained_out);
    int l;
    l = (len > 4) ? 4 : len;
    if (l == 0) begin
      exp_q.push_back(3'b001);
      return;
    end
    for (int s = 0; s < l; s++) begin
      int units;
      int gap;
      units = pat[3 - s] ? 3 : 1;
      gap   = (s == l - 1) ? 3 : 1;
      for (int c = 0; c < units * C; c++)
        exp_q.push_back({1'b1, 1'b1, (chained_in && s == 0 && c == 0)});
      for (int c = 0; c < gap * C; c++)
        exp_q.push_back(3'b010);
    end
    if (!chained_out) exp_q.push_back(3'b001);
  endtask

  // driver: present a request; the caller is at a negedge with the DUT idle
  task automatic begin_letter(input logic [3:0] pat, input logic [2:0] len, input logic ab);
    start   = 1'b1;
    pattern = pat;
    length  = len;
    abort   = ab;
  endtask

  // Runs the scoreboard one cycle per entry. Inputs change at negedges.
  task automatic play(input int hold_until, input bit noise, input int kill_at,
                      input bit kill_is_reset, input logic [3:0] next_pat,
                      input logic [2:0] next_len);
    logic [2:0] e;
    int i;
    i = 0;
    exp_q.push_back(3'b000);
    exp_q.push_back(3'b000);
    while (exp_q.size() > 0) begin
      @(posedge CLOCK_50);
      @(negedge CLOCK_50);
      e = exp_q.pop_front();
      check_val("led", led, e[2]);
      check_val("busy", busy, e[1]);
      check_val("done", done, e[0]);
      abort   = 1'b0;
      reset   = 1'b0;
      pattern = next_pat;
      length  = next_len;
      if (i == rep_drop_at) repeat_en = 1'b0;
      if (i < hold_until) begin
        start = 1'b1;
      end else if (noise && e[1] && exp_q.size() > 0 && !exp_q[0][0]) begin
        // start pulses while busy, excluding the chaining window
        start   = 1'($urandom_range(0, 1));
        pattern = 4'($urandom);
        length  = 3'($urandom);
        abort   = 1'b0;
      end else begin
        start = 1'b0;
      end
      if (i == kill_at) begin
        if (kill_is_reset) reset = 1'b1;
        else abort = 1'b1;
        start = 1'b0;
        exp_q.delete();
        repeat (4) exp_q.push_back(3'b000);
      end
      i++;
    end
    start = 1'b0;
    abort = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; repeat_en = 1'b0;
    pattern = '0; length = '0;
    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check_val("rst_led", led, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_state", state_dbg, 0);
    reset = 1'b0;
    abort = 1'b1;
    @(negedge CLOCK_50);
    check_val("idle_abort_busy", busy, 0);
    check_val("idle_abort_state", state_dbg, 0);
    abort = 1'b0;

    // Letter K
    push_letter(4'b1010, 3, 0, 0);
    begin_letter(4'b1010, 3'd3, 1'b0);
    play(0, 0, -1, 0, 4'($urandom), 3'($urandom));

    // Letter E
    push_letter(4'b0000, 1, 0, 0);
    begin_letter(4'b0000, 3'd1, 1'b0);
    play(0, 0, -1, 0, 4'($urandom), 3'($urandom));

    // length 0 and clamped length 7
    push_letter(4'b1111, 0, 0, 0);
    begin_letter(4'b1111, 3'd0, 1'b0);
    play(0, 0, -1, 0, 4'($urandom), 3'($urandom));
    push_letter(4'b0110, 7, 0, 0);
    begin_letter(4'b0110, 3'd7, 1'b0);
    play(0, 0, -1, 0, 4'($urandom), 3'($urandom));

    // abort together with start in idle: start wins (letter N)
    push_letter(4'b1000, 2, 0, 0);
    begin_letter(4'b1000, 3'd2, 1'b1);
    play(0, 0, -1, 0, 4'($urandom), 3'($urandom));

    // Letter J killed during its second mark (entries 8..19), abort then reset
    push_letter(4'b0111, 4, 0, 0);
    begin_letter(4'b0111, 3'd4, 1'b0);
    play(0, 0, 10, 0, 4'($urandom), 3'($urandom));
    check_val("abort_state", state_dbg, 0);
    push_letter(4'b0111, 4, 0, 0);
    begin_letter(4'b0111, 3'd4, 1'b0);
    play(0, 0, 10, 1, 4'($urandom), 3'($urandom));
    check_val("reset_state", state_dbg, 0);

    // chaining: start held high through K (48 busy cycles) into N
    push_letter(4'b1010, 3, 0, 1);
    push_letter(4'b1000, 2, 1, 0);
    begin_letter(4'b1010, 3'd3, 1'b0);
    play(52, 0, -1, 0, 4'b1000, 3'd2);

    // randomized letters with ignored start pulses and occasional kills
    for (int n = 0; n < 25; n++) begin
      logic [3:0] p;
      logic [2:0] l;
      int kat;
      bit krs;
      p   = 4'($urandom);
      l   = 3'($urandom_range(0, 7));
      kat = -1;
      krs = 1'($urandom_range(0, 1));
      push_letter(p, int'(l), 0, 0);
      if (l != 0 && $urandom_range(0, 3) == 0)
        kat = $urandom_range(0, exp_q.size() - 2);
      repeat ($urandom_range(0, 3)) @(negedge CLOCK_50);
      begin_letter(p, l, 1'($urandom_range(0, 1)));
      play(0, 1, kat, krs, 4'($urandom), 3'($urandom));
    end

`ifdef MORSE_REPEAT_EN
    // Letter M repeated: three passes, with repeat_en dropped in the third
    repeat_en = 1'b1;
    push_letter(4'b1100, 2, 0, 1);
    push_letter(4'b1100, 2, 1, 1);
    push_letter(4'b1100, 2, 1, 0);
    rep_drop_at = 85;
    begin_letter(4'b1100, 3'd2, 1'b0);
    play(0, 0, -1, 0, 4'($urandom), 3'($urandom));
    rep_drop_at = -1;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
